// File: rtl/sram_1r1w_port_ctrl.sv
// Front end for one 1R1W SRAM macro: round-robin read arbitration, pass-through write port,
// one-cycle tagged read response with valid/ready, same-edge write-to-read forwarding.
module sram_1r1w_port_ctrl #(
  parameter int NRD = 2,
  parameter int AW  = 17,
  parameter int DW  = 32,
  parameter int IDW = (NRD > 1) ? $clog2(NRD) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD-1:0]    rd_req_valid,
  input  logic [NRD*AW-1:0] rd_req_addr,
  output logic [NRD-1:0]    rd_req_ready,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DW-1:0]     rd_resp_data,
  output logic [IDW-1:0]    rd_resp_id,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic [AW-1:0]     sram_a1,
  output logic              sram_csb1,
  output logic              sram_oeb1,
  input  logic [DW-1:0]     sram_o1,
  output logic [AW-1:0]     sram_a2,
  output logic [DW-1:0]     sram_i2,
  output logic              sram_csb2,
  output logic              sram_web2
);

  logic [IDW-1:0] rr_q, rr_d;
  logic           resp_vld_q, resp_vld_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic           fwd_hit_q, fwd_hit_d;
  logic [DW-1:0]  fwd_data_q, fwd_data_d;

  logic           found_hi, found_lo, found;
  logic [IDW-1:0] gnt_hi, gnt_lo, gnt_idx;
  logic [AW-1:0]  gnt_addr;
  logic           slot_free, issue, wr_fire;

  // Descending scan: the last hit wins, so gnt_hi is the lowest valid index >= rr
  // and gnt_lo the lowest valid index overall (used when the scan wraps).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    gnt_hi   = '0;
    gnt_lo   = '0;
    for (int i = NRD - 1; i >= 0; i--) begin
      if (rd_req_valid[i]) begin
        if (IDW'(i) >= rr_q) begin
          found_hi = 1'b1;
          gnt_hi   = IDW'(i);
        end
        found_lo = 1'b1;
        gnt_lo   = IDW'(i);
      end
    end
    found   = found_hi | found_lo;
    gnt_idx = found_hi ? gnt_hi : gnt_lo;
  end

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NRD; i++) begin
      if (gnt_idx == IDW'(i)) gnt_addr = rd_req_addr[i*AW +: AW];
    end
  end

  assign slot_free    = ~resp_vld_q | rd_resp_ready;
  assign issue        = ~reset & slot_free & found;
  assign rd_req_ready = issue ? (NRD'(1) << gnt_idx) : '0;

  assign sram_a1   = gnt_addr;
  assign sram_csb1 = ~issue;
  assign sram_oeb1 = 1'b0;

  assign wr_ready  = ~reset;
  assign wr_fire   = wr_valid & wr_ready;
  assign sram_a2   = wr_addr;
  assign sram_i2   = wr_data;
  assign sram_csb2 = ~wr_fire;
  assign sram_web2 = ~wr_fire;

  // The macro may return stale data when read and write hit the same address on one edge,
  // so the write data is captured and substituted for that response.
  always_comb begin
    rr_d       = rr_q;
    resp_id_d  = resp_id_q;
    fwd_hit_d  = fwd_hit_q;
    fwd_data_d = fwd_data_q;
    resp_vld_d = resp_vld_q & ~rd_resp_ready;
    if (issue) begin
      resp_vld_d = 1'b1;
      resp_id_d  = gnt_idx;
      rr_d       = (gnt_idx == IDW'(NRD - 1)) ? '0 : gnt_idx + IDW'(1);
      fwd_hit_d  = wr_fire && (wr_addr == gnt_addr);
      fwd_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      resp_vld_q <= 1'b0;
      resp_id_q  <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      rr_q       <= rr_d;
      resp_vld_q <= resp_vld_d;
      resp_id_q  <= resp_id_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign rd_resp_valid = resp_vld_q;
  assign rd_resp_id    = resp_id_q;
  assign rd_resp_data  = fwd_hit_q ? fwd_data_q : sram_o1;

endmodule

// File: tb/tb_sram_1r1w_port_ctrl.sv
// Directed bench for sram_1r1w_port_ctrl with behavioural 1R1W SRAM models (NRD=2 and NRD=3).
module tb_sram_1r1w_port_ctrl;
  localparam int AW = 17;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: NRD=2
  logic [1:0]      a_req_vld, a_req_rdy;
  logic [2*AW-1:0] a_req_addr;
  logic            a_resp_vld, a_resp_rdy;
  logic [DW-1:0]   a_resp_dat;
  logic [0:0]      a_resp_id;
  logic            a_wr_vld, a_wr_rdy;
  logic [AW-1:0]   a_wr_addr, a_a1, a_a2;
  logic [DW-1:0]   a_wr_dat, a_o1, a_i2;
  logic            a_csb1, a_oeb1, a_csb2, a_web2;

  // Instance B: NRD=3
  logic [2:0]      b_req_vld, b_req_rdy;
  logic [3*AW-1:0] b_req_addr;
  logic            b_resp_vld, b_resp_rdy;
  logic [DW-1:0]   b_resp_dat;
  logic [1:0]      b_resp_id;
  logic            b_wr_vld, b_wr_rdy;
  logic [AW-1:0]   b_wr_addr, b_a1, b_a2;
  logic [DW-1:0]   b_wr_dat, b_o1, b_i2;
  logic            b_csb1, b_oeb1, b_csb2, b_web2;

  sram_1r1w_port_ctrl #(.NRD(2), .AW(AW), .DW(DW)) dut_a (
    .clk(clk), .reset(reset),
    .rd_req_valid(a_req_vld), .rd_req_addr(a_req_addr), .rd_req_ready(a_req_rdy),
    .rd_resp_valid(a_resp_vld), .rd_resp_ready(a_resp_rdy),
    .rd_resp_data(a_resp_dat), .rd_resp_id(a_resp_id),
    .wr_valid(a_wr_vld), .wr_ready(a_wr_rdy), .wr_addr(a_wr_addr), .wr_data(a_wr_dat),
    .sram_a1(a_a1), .sram_csb1(a_csb1), .sram_oeb1(a_oeb1), .sram_o1(a_o1),
    .sram_a2(a_a2), .sram_i2(a_i2), .sram_csb2(a_csb2), .sram_web2(a_web2)
  );

  sram_1r1w_port_ctrl #(.NRD(3), .AW(AW), .DW(DW)) dut_b (
    .clk(clk), .reset(reset),
    .rd_req_valid(b_req_vld), .rd_req_addr(b_req_addr), .rd_req_ready(b_req_rdy),
    .rd_resp_valid(b_resp_vld), .rd_resp_ready(b_resp_rdy),
    .rd_resp_data(b_resp_dat), .rd_resp_id(b_resp_id),
    .wr_valid(b_wr_vld), .wr_ready(b_wr_rdy), .wr_addr(b_wr_addr), .wr_data(b_wr_dat),
    .sram_a1(b_a1), .sram_csb1(b_csb1), .sram_oeb1(b_oeb1), .sram_o1(b_o1),
    .sram_a2(b_a2), .sram_i2(b_i2), .sram_csb2(b_csb2), .sram_web2(b_web2)
  );

  // Macro models: a same-edge read of a written address returns the old word.
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:255];

  always @(posedge clk) begin
    if (!a_csb1) a_o1 <= mem_a[a_a1];
    if (!a_csb2 && !a_web2) mem_a[a_a2] <= a_i2;
    if (!b_csb1) b_o1 <= mem_b[b_a1[7:0]];
    if (!b_csb2 && !b_web2) mem_b[b_a2[7:0]] <= b_i2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] dat);
    a_wr_vld  = 1'b1;
    a_wr_addr = addr;
    a_wr_dat  = dat;
    tick();
    a_wr_vld  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    a_req_vld  = 2'b11;
    a_req_addr = '0;
    a_resp_rdy = 1'b0;
    a_wr_vld   = 1'b1;
    a_wr_addr  = '0;
    a_wr_dat   = '0;
    b_req_vld  = '0;
    b_req_addr = '0;
    b_resp_rdy = 1'b1;
    b_wr_vld   = 1'b0;
    b_wr_addr  = '0;
    b_wr_dat   = '0;
    mem_b[7]   = 32'h0000_00B7;
    repeat (2) @(posedge clk);
    #2;

    // Reset values with requests and a write pending
    chk("rst_resp_vld", a_resp_vld, 0);
    chk("rst_req_rdy", a_req_rdy, 0);
    chk("rst_csb1", a_csb1, 1);
    chk("rst_wr_rdy", a_wr_rdy, 0);
    chk("rst_csb2", a_csb2, 1);
    chk("rst_web2", a_web2, 1);
    chk("rst_oeb1", a_oeb1, 0);

    reset      = 1'b0;
    a_req_vld  = '0;
    a_wr_vld   = 1'b0;
    a_resp_rdy = 1'b1;
    wr_a(17'h10, 32'h1111);
    wr_a(17'h20, 32'h2020);

    // 1: reset while a response is pending
    a_req_vld = 2'b01;
    a_req_addr[0 +: AW] = 17'd5;
    #1;
    chk("t1_rdy", a_req_rdy, 2'b01);
    chk("t1_csb1", a_csb1, 0);
    chk("t1_a1", a_a1, 17'd5);
    tick();
    a_req_vld  = '0;
    a_resp_rdy = 1'b0;
    #1;
    chk("t1_vld", a_resp_vld, 1);
    chk("t1_id", a_resp_id, 0);
    reset = 1'b1;
    #1;
    chk("t1_rst_vld", a_resp_vld, 0);
    chk("t1_rst_csb1", a_csb1, 1);
    tick();
    reset      = 1'b0;
    a_resp_rdy = 1'b1;
    tick();
    chk("t1_no_stale", a_resp_vld, 0);

    // 3: both requesters continuously valid -> 0,1,0
    a_req_vld = 2'b11;
    a_req_addr[0 +: AW]  = 17'h10;
    a_req_addr[AW +: AW] = 17'h20;
    #1;
    chk("t3_rdy0", a_req_rdy, 2'b01);
    chk("t3_a1", a_a1, 17'h10);
    tick();
    chk("t3_vld0", a_resp_vld, 1);
    chk("t3_id0", a_resp_id, 0);
    chk("t3_dat0", a_resp_dat, 32'h1111);
    chk("t3_rdy1", a_req_rdy, 2'b10);
    tick();
    chk("t3_id1", a_resp_id, 1);
    chk("t3_dat1", a_resp_dat, 32'h2020);
    chk("t3_rdy2", a_req_rdy, 2'b01);
    tick();
    chk("t3_vld2", a_resp_vld, 1);
    chk("t3_id2", a_resp_id, 0);
    chk("t3_dat2", a_resp_dat, 32'h1111);
    a_req_vld = '0;
    tick();
    chk("t3_drain", a_resp_vld, 0);

    // 2: write then read the top address next cycle (rr is now 1)
    a_wr_vld  = 1'b1;
    a_wr_addr = 17'h1FFFF;
    a_wr_dat  = 32'hDEADBEEF;
    #1;
    chk("t2_wr_rdy", a_wr_rdy, 1);
    chk("t2_csb2", a_csb2, 0);
    chk("t2_web2", a_web2, 0);
    chk("t2_a2", a_a2, 17'h1FFFF);
    chk("t2_i2", a_i2, 32'hDEADBEEF);
    tick();
    a_wr_vld  = 1'b0;
    a_req_vld = 2'b01;
    a_req_addr[0 +: AW] = 17'h1FFFF;
    #1;
    chk("t2_rdy", a_req_rdy, 2'b01);
    tick();
    a_req_vld = '0;
    chk("t2_vld", a_resp_vld, 1);
    chk("t2_dat", a_resp_dat, 32'hDEADBEEF);
    chk("t2_id", a_resp_id, 0);
    tick();

    // 4: read and write 0x10 on the same edge -> new data forwarded
    a_req_vld = 2'b01;
    a_req_addr[0 +: AW] = 17'h10;
    a_wr_vld  = 1'b1;
    a_wr_addr = 17'h10;
    a_wr_dat  = 32'h2222;
    tick();
    chk("t4_vld", a_resp_vld, 1);
    chk("t4_fwd", a_resp_dat, 32'h2222);
    a_req_addr[0 +: AW] = 17'h20;
    a_wr_addr = 17'h30;
    a_wr_dat  = 32'h3030;
    #1;
    chk("t4_rdy", a_req_rdy, 2'b01);
    tick();
    a_wr_vld = 1'b0;
    chk("t4_fwd_clr", a_resp_dat, 32'h2020);
    chk("t4_id", a_resp_id, 0);

    // 5: backpressure for 5 cycles, rr is 1
    a_resp_rdy = 1'b0;
    a_req_vld  = 2'b11;
    a_req_addr[0 +: AW]  = 17'h30;
    a_req_addr[AW +: AW] = 17'h1FFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_csb1", a_csb1, 1);
      chk("t5_rdy", a_req_rdy, 2'b00);
      chk("t5_vld", a_resp_vld, 1);
      chk("t5_dat", a_resp_dat, 32'h2020);
      tick();
    end
    a_resp_rdy = 1'b1;
    #1;
    chk("t5_rel_rdy", a_req_rdy, 2'b10);
    chk("t5_rel_a1", a_a1, 17'h1FFFF);
    tick();
    chk("t5_dat1", a_resp_dat, 32'hDEADBEEF);
    chk("t5_id1", a_resp_id, 1);
    chk("t5_rdy2", a_req_rdy, 2'b01);
    tick();
    chk("t5_dat0", a_resp_dat, 32'h3030);
    chk("t5_id0", a_resp_id, 0);
    a_req_vld = '0;
    tick();
    chk("t5_drain", a_resp_vld, 0);

    // 6: NRD=3, only requester 2 valid, then wrap to 0
    b_req_vld = 3'b100;
    b_req_addr[2*AW +: AW] = 17'd7;
    #1;
    chk("t6_rdy", b_req_rdy, 3'b100);
    chk("t6_a1", b_a1, 17'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_vld", b_resp_vld, 1);
      chk("t6_id", b_resp_id, 2);
      chk("t6_dat", b_resp_dat, 32'h0000_00B7);
      chk("t6_rdy_n", b_req_rdy, 3'b100);
    end
    b_req_vld = 3'b111;
    b_req_addr[0 +: AW]  = 17'd1;
    b_req_addr[AW +: AW] = 17'd2;
    #1;
    chk("t6_wrap_rdy", b_req_rdy, 3'b001);
    tick();
    chk("t6_wrap_id", b_resp_id, 0);
    chk("t6_next_rdy", b_req_rdy, 3'b010);
    tick();
    chk("t6_next_id", b_resp_id, 1);
    b_req_vld = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
